seg_display_decoder: RTL and testbench

Self-check monitor that reads the four 7-segment display buses and the DOT line back into digit codes. It is the decoding end of the timer's seven-segment interface. It sits beside the timer top level on the board and in benches, debounces each display pattern, flags illegal patterns, and optionally measures the DOT flash period. Outputs feed LEDs and debug taps, and let benches check the display without a per-pattern scoreboard.

---
 rtl/seg_display_decoder.sv | 161 ++++++++++++++++
 tb/tb_seg_display_decoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seg_display_decoder.sv
// seg_display_decoder: debounces the four 7-segment buses back into digit codes and flags illegal patterns.
// Optional `SEG_DOT_MEASURE_EN adds a measurement of the DOT rising-edge period.
module seg_display_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int STAB_W = 8,
    parameter int PERIOD_W = 32
) (
    input  logic                CLK_50MHz,
    input  logic                rst,
    input  logic [6:0]          HexMSBH,
    input  logic [6:0]          HexMSBL,
    input  logic [6:0]          HexLSBH,
    input  logic [6:0]          HexLSBL,
    input  logic                DOT,
    output logic [3:0]          digit_mh,
    output logic [3:0]          digit_ml,
    output logic [3:0]          digit_lh,
    output logic [3:0]          digit_ll,
    output logic [3:0]          blank,
    output logic                valid,
    output logic                upd_pulse,
    output logic                err_pulse,
    output logic [7:0]          err_cnt,
    output logic [PERIOD_W-1:0] dot_period,
    output logic                dot_period_vld
);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_HIT = STAB_W'(STABLE_CYCLES - 1);

    // returns {blank, code}; active-low segments, bit0=a
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40:   decode = 5'h00;
            7'h79:   decode = 5'h01;
            7'h24:   decode = 5'h02;
            7'h30:   decode = 5'h03;
            7'h19:   decode = 5'h04;
            7'h12:   decode = 5'h05;
            7'h02:   decode = 5'h06;
            7'h78:   decode = 5'h07;
            7'h00:   decode = 5'h08;
            7'h10:   decode = 5'h09;
            7'h7F:   decode = 5'h1F;
            default: decode = 5'h0E;
        endcase
    endfunction

    logic [3:0][6:0]        seg, prev_q, prev_d;
    logic [3:0][STAB_W-1:0] cnt_q, cnt_d;
    logic [3:0][3:0]        code_q, code_d;
    logic [3:0][4:0]        dec;
    logic [3:0]             blank_q, blank_d, cmtd_q, cmtd_d, commit, changed, bad, is_e;
    logic [2:0]             n_bad;
    logic [8:0]             err_sum;
    logic [7:0]             err_cnt_q, err_cnt_d;
    logic                   valid_q, valid_d, upd_q, err_q;

    assign seg = {HexMSBH, HexMSBL, HexLSBH, HexLSBL};

    always_comb begin
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        blank_d = blank_q;
        cmtd_d  = cmtd_q;
        dec     = '0;
        commit  = '0;
        changed = '0;
        bad     = '0;
        is_e    = '0;
        n_bad   = '0;
        for (int i = 0; i < 4; i++) begin
            dec[i] = decode(seg[i]);
            if (seg[i] == prev_q[i]) begin
                cnt_d[i]  = (cnt_q[i] == STAB_MAX) ? cnt_q[i] : cnt_q[i] + STAB_W'(1);
                commit[i] = (cnt_q[i] == STAB_HIT);
            end else begin
                cnt_d[i]  = '0;
                prev_d[i] = seg[i];
            end
            if (commit[i]) begin
                {blank_d[i], code_d[i]} = dec[i];
                cmtd_d[i]  = 1'b1;
                changed[i] = !cmtd_q[i] || (dec[i][3:0] != code_q[i]);
                bad[i]     = (dec[i][3:0] == 4'hE);
            end
            is_e[i] = (code_d[i] == 4'hE);
            n_bad   = n_bad + {2'b0, bad[i]};
        end
        err_sum   = {1'b0, err_cnt_q} + {6'b0, n_bad};
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
        valid_d   = (&cmtd_d) && !(|is_e);
    end

    always_ff @(posedge CLK_50MHz) begin
        if (rst) begin
            prev_q    <= {4{7'h7F}};
            cnt_q     <= '0;
            code_q    <= {4{4'hF}};
            blank_q   <= '0;
            cmtd_q    <= '0;
            err_cnt_q <= '0;
            valid_q   <= 1'b0;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            blank_q   <= blank_d;
            cmtd_q    <= cmtd_d;
            err_cnt_q <= err_cnt_d;
            valid_q   <= valid_d;
            upd_q     <= |changed;
            err_q     <= |bad;
        end
    end

    assign {digit_mh, digit_ml, digit_lh, digit_ll} = code_q;
    assign blank     = blank_q;
    assign valid     = valid_q;
    assign upd_pulse = upd_q;
    assign err_pulse = err_q;
    assign err_cnt   = err_cnt_q;

`ifdef SEG_DOT_MEASURE_EN
    logic                dot_q, armed_q, pvld_q;
    logic [PERIOD_W-1:0] pcnt_q, period_q;

    // first rising edge only arms the counter; later edges latch the elapsed cycles
    always_ff @(posedge CLK_50MHz) begin
        if (rst) begin
            dot_q    <= 1'b0;
            armed_q  <= 1'b0;
            pvld_q   <= 1'b0;
            pcnt_q   <= '0;
            period_q <= '0;
        end else begin
            dot_q <= DOT;
            if (DOT && !dot_q) begin
                if (armed_q) begin
                    period_q <= (&pcnt_q) ? pcnt_q : pcnt_q + PERIOD_W'(1);
                    pvld_q   <= 1'b1;
                end
                armed_q <= 1'b1;
                pcnt_q  <= '0;
            end else if (!(&pcnt_q)) begin
                pcnt_q <= pcnt_q + PERIOD_W'(1);
            end
        end
    end

    assign dot_period     = period_q;
    assign dot_period_vld = pvld_q;
`else
    logic unused_dot;
    assign unused_dot     = DOT;
    assign dot_period     = '0;
    assign dot_period_vld = 1'b0;
`endif
endmodule

// File: tb/tb_seg_display_decoder.sv
// tb_seg_display_decoder: directed stimulus with a pulse-driven scoreboard for seg_display_decoder.
module tb_seg_display_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  mh, ml, lh, ll;
    logic        dot;
    logic [3:0]  digit_mh, digit_ml, digit_lh, digit_ll, blank;
    logic        valid, upd_pulse, err_pulse, dot_period_vld;
    logic [7:0]  err_cnt;
    logic [31:0] dot_period;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [30:0] v;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    logic [30:0] got;

    seg_display_decoder dut (
        .CLK_50MHz(clk), .rst(rst),
        .HexMSBH(mh), .HexMSBL(ml), .HexLSBH(lh), .HexLSBL(ll), .DOT(dot),
        .digit_mh(digit_mh), .digit_ml(digit_ml), .digit_lh(digit_lh), .digit_ll(digit_ll),
        .blank(blank), .valid(valid), .upd_pulse(upd_pulse), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .dot_period(dot_period), .dot_period_vld(dot_period_vld)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] g, input logic [31:0] w);
        checks++;
        if (g !== w) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)", name, g, w, cyc);
        end
    endtask

    // expected {digits, blank, valid, upd, err, err_cnt} seen at cycle c
    function automatic void expect_ev(input int c, input logic [15:0] d, input logic [3:0] b,
                                      input logic v, input logic u, input logic er, input logic [7:0] n);
        exp_t x;
        x.cyc = c;
        x.v   = {d, b, v, u, er, n};
        sb.push_back(x);
    endfunction

    always @(negedge clk) begin
        if (upd_pulse || err_pulse) begin
            checks++;
            got = {digit_mh, digit_ml, digit_lh, digit_ll, blank, valid, upd_pulse, err_pulse, err_cnt};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: cyc %0d got %0h required no pulse", cyc, got);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.v !== got) begin
                    errors++;
                    $display("FAIL event: cyc %0d got %0h required cyc %0d value %0h", cyc, got, e.cyc, e.v);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        {mh, ml, lh, ll} = {4{7'h40}};
        dot = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("rst_digits", {16'h0, digit_mh, digit_ml, digit_lh, digit_ll}, 32'hFFFF);
        chk("rst_blank", {28'h0, blank}, 32'h0);
        chk("rst_flags", {28'h0, valid, upd_pulse, err_pulse, dot_period_vld}, 32'h0);
        chk("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
        chk("rst_dot_period", dot_period, 32'h0);
        expect_ev(7, 16'h0000, 4'b0000, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(6);
        chk("all_zero", {16'h0, digit_mh, digit_ml, digit_lh, digit_ll}, 32'h0000);
        chk("valid_after_zero", {31'h0, valid}, 32'h1);

        ll = 7'h79;
        expect_ev(13, 16'h0001, 4'b0000, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(4);
        chk("ll_not_yet", {28'h0, digit_ll}, 32'h0);
        tick(3);
        chk("ll_one", {16'h0, digit_mh, digit_ml, digit_lh, digit_ll}, 32'h0001);

        for (int i = 0; i < 10; i++) begin
            mh = (i % 2 != 0) ? 7'h30 : 7'h24;
            tick(2);
        end
        mh = 7'h40;
        tick(6);
        chk("glitch_mh_kept", {28'h0, digit_mh}, 32'h0);

        ml = 7'h55;
        expect_ev(46, 16'h0E01, 4'b0000, 1'b0, 1'b1, 1'b1, 8'd1);
        tick(6);
        lh = 7'h7E;
        expect_ev(52, 16'h0EE1, 4'b0000, 1'b0, 1'b1, 1'b1, 8'd2);
        tick(6);
        chk("err_cnt_two", {24'h0, err_cnt}, 32'd2);
        chk("invalid_not_valid", {31'h0, valid}, 32'h0);
        ml = 7'h7F;
        lh = 7'h7F;
        expect_ev(58, 16'h0FF1, 4'b0110, 1'b1, 1'b1, 1'b0, 8'd2);
        tick(6);
        chk("blank_bits", {28'h0, blank}, 32'b0110);

        mh = 7'h55;
        ll = 7'h7E;
        expect_ev(64, 16'hEFFE, 4'b0110, 1'b0, 1'b1, 1'b1, 8'd4);
        tick(6);
        chk("err_cnt_plus_two", {24'h0, err_cnt}, 32'd4);

        {mh, ml, lh, ll} = {4{7'h19}};
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_digits", {16'h0, digit_mh, digit_ml, digit_lh, digit_ll}, 32'hFFFF);
        chk("midrst_state", {19'h0, blank, valid, upd_pulse, err_pulse, err_cnt}, 32'h0);
        expect_ev(73, 16'h4444, 4'b0000, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(4);
        chk("requalify_wait", {16'h0, digit_mh, digit_ml, digit_lh, digit_ll}, 32'hFFFF);
        tick(2);
        chk("requalified", {16'h0, digit_mh, digit_ml, digit_lh, digit_ll}, 32'h4444);

        for (int i = 0; i < 3; i++) begin
            dot = 1'b1;
            tick(5);
            dot = 1'b0;
            tick(5);
`ifdef SEG_DOT_MEASURE_EN
            if (i == 0) chk("dot_vld_armed_only", {31'h0, dot_period_vld}, 32'h0);
`else
            chk("dot_period_tied", dot_period, 32'h0);
            chk("dot_vld_tied", {31'h0, dot_period_vld}, 32'h0);
`endif
        end
`ifdef SEG_DOT_MEASURE_EN
        chk("dot_period", dot_period, 32'd10);
        chk("dot_vld", {31'h0, dot_period_vld}, 32'h1);
`endif
        tick(5);
        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
